// File: rtl/tub_bp_pkg.sv
// Shared types and constants for the trigger-utility-board backplane loader.
// Pin indices locate the serial pins on the crate backplane connector.
package tub_bp_pkg;

    localparam int DIV_W = 8;

    localparam int PIN_SCLK   = 3;
    localparam int PIN_SDATA  = 4;
    localparam int PIN_SLATCH = 5;
    localparam int PIN_SDIN   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/tub_bp_clkdiv.sv
// Terminal-count divider: ticks on every DIV-th enabled cycle.
// Clear forces the count back to zero so each phase starts aligned.
module tub_bp_clkdiv
    import tub_bp_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] TC = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == TC);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tub_bp_serial_loader.sv
// Serial backplane loader: shifts a word out MSB-first on SCLK, pulses
// SLATCH, and captures the daisy-chained SDIN readback in the same pass.
module tub_bp_serial_loader
    import tub_bp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             WR_VALID,
    output logic             READY,
    output logic             SCLK,
    output logic             SDATA,
    output logic             SLATCH,
    input  logic             SDIN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] rreg_q;
    logic [WIDTH-1:0] rreg_d;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;
    logic [CNT_W-1:0] bcnt_q;
    logic [CNT_W-1:0] bcnt_d;
    logic             ready_q;
    logic             ready_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             sdata_q;
    logic             sdata_d;
    logic             slatch_q;
    logic             slatch_d;
    logic             done_q;
    logic             done_d;
    logic             sdin1_q;
    logic             sdin1_d;
    logic             sdin2_q;
    logic             sdin2_d;
    logic             rise1_q;
    logic             rise1_d;
    logic             rise2_q;
    logic             rise2_d;
    logic             accept;
    logic             div_en;
    logic             tick;

    assign div_en = (state_q == ST_SHIFT_LO) ||
                    (state_q == ST_SHIFT_HI) ||
                    (state_q == ST_LATCH);

    tub_bp_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (!div_en),
        .en    (div_en),
        .tick  (tick)
    );

    // Pins lag the state by one cycle, so READY gates acceptance too.
    assign accept = (state_q == ST_IDLE) && ready_q && WR_VALID;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d  = WR_DATA;
                    bcnt_d  = CNT_W'(WIDTH - 1);
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (bcnt_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        bcnt_d  = bcnt_q - CNT_W'(1);
                        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready_d  = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        sclk_d   = (state_q == ST_SHIFT_HI);
        slatch_d = (state_q == ST_LATCH);
        done_d   = (state_q == ST_DONE);
        sdata_d  = 1'b0;
        if (state_q == ST_SHIFT_LO) begin
            sdata_d = sreg_q[WIDTH-1];
        end else if (state_q == ST_SHIFT_HI) begin
            sdata_d = sdata_q;
        end
    end

    // SDIN passes two sync flops; the rise flag is delayed to match so
    // the captured bit is the one present before the SCLK rising edge.
    always_comb begin
        sdin1_d = SDIN;
        sdin2_d = sdin1_q;
        rise1_d = sclk_d && !sclk_q;
        rise2_d = rise1_q;
        rreg_d  = rreg_q;
        if (accept) begin
            rreg_d = '0;
        end else if (rise2_q) begin
            rreg_d = {rreg_q[WIDTH-2:0], sdin2_q};
        end
        rd_d = done_d ? rreg_d : rd_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            rreg_q   <= '0;
            rd_q     <= '0;
            bcnt_q   <= '0;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            slatch_q <= 1'b0;
            done_q   <= 1'b0;
            sdin1_q  <= 1'b0;
            sdin2_q  <= 1'b0;
            rise1_q  <= 1'b0;
            rise2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            rreg_q   <= rreg_d;
            rd_q     <= rd_d;
            bcnt_q   <= bcnt_d;
            ready_q  <= ready_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            slatch_q <= slatch_d;
            done_q   <= done_d;
            sdin1_q  <= sdin1_d;
            sdin2_q  <= sdin2_d;
            rise1_q  <= rise1_d;
            rise2_q  <= rise2_d;
        end
    end

    assign READY   = ready_q;
    assign SCLK    = sclk_q;
    assign SDATA   = sdata_q;
    assign SLATCH  = slatch_q;
    assign RD_DATA = rd_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_tub_bp_serial_loader.sv
// Bench for tub_bp_serial_loader: three instances (8/2, 8/1, 32/4) share
// one clock and reset; a scoreboard checks every DONE pulse.
module tb_tub_bp_serial_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] wr;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] data;
        logic        lb;
        logic        sin;
        logic [31:0] rd;
    } vec_t;

    int W[3] = '{8, 8, 32};
    int D[3] = '{2, 1, 4};

    exp_t exp_q[3][$];
    int   acc_q[3][$];

    logic [31:0] wr_data[3];
    logic        wr_valid[3];
    logic        lb[3];
    logic        sfix[3];

    logic        ready[3];
    logic        sclk[3];
    logic        sdata[3];
    logic        slatch[3];
    logic        done[3];
    logic [31:0] rd[3];

    logic        sclk_p[3];
    int          rises[3];
    int          lat[3];
    int          ndone[3];
    logic [31:0] smp[3];

    int chk = 0;
    int pass = 0;

    logic       rdy0, sck0, sda0, slt0, dn0, sdi0;
    logic       rdy1, sck1, sda1, slt1, dn1, sdi1;
    logic       rdy2, sck2, sda2, slt2, dn2, sdi2;
    logic [7:0] rd0, rd1;
    logic [31:0] rd2;

    assign sdi0 = lb[0] ? sda0 : sfix[0];
    assign sdi1 = lb[1] ? sda1 : sfix[1];
    assign sdi2 = lb[2] ? sda2 : sfix[2];

    tub_bp_serial_loader #(.WIDTH(8), .DIV(2)) u0 (
        .CLK(clk), .RST_N(rst_n), .WR_DATA(wr_data[0][7:0]),
        .WR_VALID(wr_valid[0]), .READY(rdy0), .SCLK(sck0), .SDATA(sda0),
        .SLATCH(slt0), .SDIN(sdi0), .RD_DATA(rd0), .DONE(dn0));

    tub_bp_serial_loader #(.WIDTH(8), .DIV(1)) u1 (
        .CLK(clk), .RST_N(rst_n), .WR_DATA(wr_data[1][7:0]),
        .WR_VALID(wr_valid[1]), .READY(rdy1), .SCLK(sck1), .SDATA(sda1),
        .SLATCH(slt1), .SDIN(sdi1), .RD_DATA(rd1), .DONE(dn1));

    tub_bp_serial_loader #(.WIDTH(32), .DIV(4)) u2 (
        .CLK(clk), .RST_N(rst_n), .WR_DATA(wr_data[2]),
        .WR_VALID(wr_valid[2]), .READY(rdy2), .SCLK(sck2), .SDATA(sda2),
        .SLATCH(slt2), .SDIN(sdi2), .RD_DATA(rd2), .DONE(dn2));

    always_comb begin
        ready  = '{rdy0, rdy1, rdy2};
        sclk   = '{sck0, sck1, sck2};
        sdata  = '{sda0, sda1, sda2};
        slatch = '{slt0, slt1, slt2};
        done   = '{dn0, dn1, dn2};
        rd     = '{{24'd0, rd0}, {24'd0, rd1}, rd2};
    end

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        chk++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic void fail(string nm, string msg);
        chk++;
        $display("FAIL %s: %s", nm, msg);
    endfunction

    function automatic logic [31:0] mask(int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Scoreboard monitor: samples away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ready[k] && wr_valid[k]) acc_q[k].push_back(cyc + 1);
            if (sclk[k] && !sclk_p[k]) begin
                rises[k]++;
                smp[k] = {smp[k][30:0], sdata[k]};
            end
            if (slatch[k]) lat[k]++;
            if (done[k]) begin
                ndone[k]++;
                if (exp_q[k].size() == 0 || acc_q[k].size() == 0) begin
                    fail($sformatf("done%0d", k), "unexpected DONE pulse");
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q[k].pop_front();
                    a = acc_q[k].pop_front();
                    check($sformatf("rd_data%0d", k), rd[k], e.rd);
                    check($sformatf("latency%0d", k), cyc - a,
                          1 + 2 * D[k] * W[k] + D[k]);
                    check($sformatf("sdata_word%0d", k),
                          smp[k] & mask(W[k]), e.wr & mask(W[k]));
                    check($sformatf("sclk_rises%0d", k), rises[k], W[k]);
                    check($sformatf("slatch_len%0d", k), lat[k], D[k]);
                    check($sformatf("ready_at_done%0d", k), ready[k], 0);
                end
                rises[k] = 0;
                lat[k]   = 0;
                smp[k]   = '0;
            end
            sclk_p[k] = sclk[k];
        end
    end

    task automatic wait_ready(int k);
        int c = 0;
        while (!ready[k] && c < 1000) begin
            @(negedge clk); #1; c++;
        end
        if (!ready[k]) fail($sformatf("ready_wait%0d", k), "timeout");
    endtask

    task automatic send(int k, logic [31:0] d, logic l, logic s, logic [31:0] e);
        wait_ready(k);
        lb[k] = l;
        sfix[k] = s;
        wr_data[k] = d;
        exp_q[k].push_back('{d, e});
        @(posedge clk); #1;
        wr_valid[k] = 1'b1;
        @(posedge clk); #1;
        wr_valid[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int n, int budget);
        int c = 0;
        while (ndone[k] < n && c < budget) begin
            @(negedge clk); #1; c++;
        end
        if (ndone[k] < n) fail($sformatf("done_wait%0d", k), "timeout");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[6];
    int   n;
    int   stray;
    int   c;

    initial begin
        for (int k = 0; k < 3; k++) begin
            wr_data[k] = '0; wr_valid[k] = 1'b0; lb[k] = 1'b0; sfix[k] = 1'b0;
            sclk_p[k] = 1'b0; rises[k] = 0; lat[k] = 0; ndone[k] = 0;
            smp[k] = '0;
        end
        vecs[0] = '{0, 32'h0000_00A5, 1'b1, 1'b0, 32'h0000_00A5};
        vecs[1] = '{1, 32'h0000_00FF, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2] = '{2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{0, 32'h0000_005A, 1'b0, 1'b1, 32'h0000_00FF};
        vecs[4] = '{1, 32'h0000_0096, 1'b1, 1'b0, 32'h0000_0096};
        vecs[5] = '{2, 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_sdata", sdata[0], 0);
        check("rst_slatch", slatch[2], 0);
        check("rst_rd", rd[2], 0);
        check("rst_done", done[1], 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            n = ndone[vecs[i].k];
            send(vecs[i].k, vecs[i].data, vecs[i].lb, vecs[i].sin, vecs[i].rd);
            wait_done(vecs[i].k, n + 1, 400);
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("rd_hold%0d", i), rd[vecs[i].k], vecs[i].rd);
        end

        // back-to-back with WR_VALID held high
        n = ndone[0];
        wait_ready(0);
        lb[0] = 1'b1;
        wr_data[0] = 32'h3C;
        exp_q[0].push_back('{32'h3C, 32'h3C});
        @(posedge clk); #1;
        wr_valid[0] = 1'b1;
        @(posedge clk); #1;
        wr_data[0] = 32'hC3;
        exp_q[0].push_back('{32'hC3, 32'hC3});
        wait_done(0, n + 1, 100);
        @(negedge clk); #1;
        check("b2b_idle_gap", ready[0], 1);
        @(negedge clk); #1;
        check("b2b_restart", ready[0], 0);
        wr_valid[0] = 1'b0;
        wait_done(0, n + 2, 100);

        // WR_VALID mid-transfer is ignored
        n = ndone[0];
        send(0, 32'h5A, 1'b1, 1'b0, 32'h5A);
        repeat (4) @(posedge clk);
        #1;
        wr_data[0] = 32'h11;
        wr_valid[0] = 1'b1;
        @(posedge clk); #1;
        wr_valid[0] = 1'b0;
        stray = 0;
        c = 0;
        while (ndone[0] < n + 1 && c < 100) begin
            @(negedge clk); #1;
            if (ready[0] && ndone[0] < n + 1) stray++;
            c++;
        end
        check("ignored_ready_low", stray, 0);
        check("ignored_done_count", ndone[0], n + 1);

        // reset in the middle of a 0x81 transfer
        send(0, 32'h81, 1'b0, 1'b1, 32'h81);
        c = 0;
        while (rises[0] < 3 && c < 100) begin
            @(negedge clk); #1; c++;
        end
        check("mid_rises", rises[0], 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sclk", sclk[0], 0);
        check("mid_rst_sdata", sdata[0], 0);
        check("mid_rst_slatch", slatch[0], 0);
        check("mid_rst_ready", ready[0], 1);
        check("mid_rst_rd", rd[0], 0);
        check("mid_no_latch", lat[0], 0);
        exp_q[0].delete();
        acc_q[0].delete();
        rises[0] = 0;
        smp[0] = '0;
        n = ndone[0];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("post_rst_ready", ready[0], 1);
        check("post_rst_rd", rd[0], 0);
        check("post_rst_no_latch", lat[0], 0);
        check("post_rst_no_done", ndone[0], n);

        n = ndone[0];
        send(0, 32'hA5, 1'b1, 1'b0, 32'hA5);
        wait_done(0, n + 1, 100);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
